// File: rtl/adma_atx_splitter_if.sv
// Request/transaction bundle for the ADMA AXI transaction splitter.
// The slave modport is the splitter; the master modport is the requester/consumer side.
interface adma_atx_splitter_if #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int SRC_ADDR_W    = 32,
  parameter int DST_ADDR_W    = 32,
  parameter int MST_ID_W      = 5,
  parameter int ATX_LEN_W     = 8,
  parameter int XFER_LEN_W    = 16,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
);
  logic [DMA_CHN_NUM_W-1:0] req_chn_id;
  logic [MST_ID_W-1:0]      req_arid;
  logic [MST_ID_W-1:0]      req_awid;
  logic [SRC_ADDR_W-1:0]    req_src_addr;
  logic [DST_ADDR_W-1:0]    req_dst_addr;
  logic [XFER_LEN_W-1:0]    req_len;
  logic [1:0]               req_arburst;
  logic [1:0]               req_awburst;
  logic                     req_vld;
  logic                     req_rdy;

  logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
  logic [MST_ID_W-1:0]      atx_arid;
  logic [SRC_ADDR_W-1:0]    atx_araddr;
  logic [ATX_LEN_W-1:0]     atx_arlen;
  logic [1:0]               atx_arburst;
  logic [MST_ID_W-1:0]      atx_awid;
  logic [DST_ADDR_W-1:0]    atx_awaddr;
  logic [ATX_LEN_W-1:0]     atx_awlen;
  logic [1:0]               atx_awburst;
  logic                     atx_last;
  logic                     atx_vld;
  logic                     atx_rdy;

  modport slave (
    input  req_chn_id, req_arid, req_awid, req_src_addr, req_dst_addr,
           req_len, req_arburst, req_awburst, req_vld, atx_rdy,
    output req_rdy, atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst,
           atx_awid, atx_awaddr, atx_awlen, atx_awburst, atx_last, atx_vld
  );

  modport master (
    output req_chn_id, req_arid, req_awid, req_src_addr, req_dst_addr,
           req_len, req_arburst, req_awburst, req_vld, atx_rdy,
    input  req_rdy, atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst,
           atx_awid, atx_awaddr, atx_awlen, atx_awburst, atx_last, atx_vld
  );
endinterface

// File: rtl/adma_atx_splitter.sv
// Splits one DMA copy request into AXI read/write transaction pairs that respect
// the AXI length limit, the 16-beat FIXED limit and 4 KB boundaries on both sides.
module adma_atx_splitter #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int SRC_ADDR_W    = 32,
  parameter int DST_ADDR_W    = 32,
  parameter int MST_ID_W      = 5,
  parameter int ATX_LEN_W     = 8,
  parameter int ATX_DATA_W    = 256,
  parameter int XFER_LEN_W    = 16,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  adma_atx_splitter_if.slave  io_if,
  output logic                o_busy
);

  localparam int BYTES = ATX_DATA_W / 8;
  localparam int S     = $clog2(BYTES);
  localparam int CW    = 32;
  localparam logic [1:0]    BURST_FIXED = 2'b00;
  localparam logic [CW-1:0] LEN_CAP     = CW'(1) << ATX_LEN_W;
  localparam logic [CW-1:0] FIXED_CAP   = CW'(16);
  localparam logic [CW-1:0] NO_LIMIT    = '1;
  localparam logic [SRC_ADDR_W-1:0] SRC_MASK = ~(SRC_ADDR_W'(BYTES - 1));
  localparam logic [DST_ADDR_W-1:0] DST_MASK = ~(DST_ADDR_W'(BYTES - 1));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DMA_CHN_NUM_W-1:0] r_chn_id;
  logic [MST_ID_W-1:0]      r_arid;
  logic [MST_ID_W-1:0]      r_awid;
  logic [SRC_ADDR_W-1:0]    r_araddr;
  logic [DST_ADDR_W-1:0]    r_awaddr;
  logic [1:0]               r_arburst;
  logic [1:0]               r_awburst;
  logic [XFER_LEN_W-1:0]    r_remaining;
  logic [ATX_LEN_W:0]       r_chunk;
  logic [ATX_LEN_W-1:0]     r_atx_len;
  logic                     r_atx_last;

  logic                     w_req_fire;
  logic                     w_atx_fire;
  logic [12:0]              w_src_off;
  logic [12:0]              w_dst_off;
  logic [CW-1:0]            w_src_bnd;
  logic [CW-1:0]            w_dst_bnd;
  logic [CW-1:0]            w_cap_fixed;
  logic [CW-1:0]            w_chunk;

  assign w_req_fire = io_if.req_vld && (r_state == ST_IDLE);
  assign w_atx_fire = io_if.atx_rdy && (r_state == ST_ISSUE);

  // Beats left before each side crosses its 4 KB page; FIXED bursts never advance.
  assign w_src_off = 13'h1000 - {1'b0, r_araddr[11:0]};
  assign w_dst_off = 13'h1000 - {1'b0, r_awaddr[11:0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_src_bnd   = NO_LIMIT;
    w_dst_bnd   = NO_LIMIT;
    w_cap_fixed = NO_LIMIT;
    w_chunk     = CW'(r_remaining);
    if (r_arburst != BURST_FIXED) w_src_bnd = CW'(w_src_off >> S);
    if (r_awburst != BURST_FIXED) w_dst_bnd = CW'(w_dst_off >> S);
    if ((r_arburst == BURST_FIXED) || (r_awburst == BURST_FIXED)) w_cap_fixed = FIXED_CAP;
    if (w_chunk > LEN_CAP)     w_chunk = LEN_CAP;
    if (w_chunk > w_cap_fixed) w_chunk = w_cap_fixed;
    if (w_chunk > w_src_bnd)   w_chunk = w_src_bnd;
    if (w_chunk > w_dst_bnd)   w_chunk = w_dst_bnd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (io_if.req_vld) w_state_nxt = ST_CALC;
      ST_CALC:  w_state_nxt = (r_remaining == '0) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: if (io_if.atx_rdy) w_state_nxt = r_atx_last ? ST_IDLE : ST_CALC;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chn_id    <= '0;
      r_arid      <= '0;
      r_awid      <= '0;
      r_araddr    <= '0;
      r_awaddr    <= '0;
      r_arburst   <= '0;
      r_awburst   <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
      r_atx_len   <= '0;
      r_atx_last  <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_chn_id    <= io_if.req_chn_id;
        r_arid      <= io_if.req_arid;
        r_awid      <= io_if.req_awid;
        r_araddr    <= io_if.req_src_addr & SRC_MASK;
        r_awaddr    <= io_if.req_dst_addr & DST_MASK;
        r_arburst   <= io_if.req_arburst;
        r_awburst   <= io_if.req_awburst;
        r_remaining <= io_if.req_len;
      end
      if ((r_state == ST_CALC) && (r_remaining != '0)) begin
        r_chunk    <= (ATX_LEN_W + 1)'(w_chunk);
        r_atx_len  <= ATX_LEN_W'(w_chunk - CW'(1));
        r_atx_last <= (CW'(r_remaining) == w_chunk);
      end
      // Addresses wrap silently at the top of the address space.
      if (w_atx_fire) begin
        r_remaining <= r_remaining - XFER_LEN_W'(r_chunk);
        if (r_arburst != BURST_FIXED) r_araddr <= r_araddr + (SRC_ADDR_W'(r_chunk) << S);
        if (r_awburst != BURST_FIXED) r_awaddr <= r_awaddr + (DST_ADDR_W'(r_chunk) << S);
      end
    end
  end

  assign io_if.req_rdy     = (r_state == ST_IDLE);
  assign io_if.atx_vld     = (r_state == ST_ISSUE);
  assign io_if.atx_chn_id  = r_chn_id;
  assign io_if.atx_arid    = r_arid;
  assign io_if.atx_araddr  = r_araddr;
  assign io_if.atx_arlen   = r_atx_len;
  assign io_if.atx_arburst = r_arburst;
  assign io_if.atx_awid    = r_awid;
  assign io_if.atx_awaddr  = r_awaddr;
  assign io_if.atx_awlen   = r_atx_len;
  assign io_if.atx_awburst = r_awburst;
  assign io_if.atx_last    = r_atx_last;
  assign o_busy            = (r_state != ST_IDLE);

endmodule
